// File: rtl/multi_channel_fifo_queue_pkg.sv
// Shared defaults and helpers for multi_channel_fifo_queue.
// Optional almost-full outputs are enabled by FIFO_QUEUE_ALMOST_FULL_EN.
package multi_channel_fifo_queue_pkg;

  localparam int MCFQ_NUM_CHANNELS = 4;
  localparam int MCFQ_CH_ID_W = 2;
  localparam int MCFQ_QUEUE_SIZE = 8;
  localparam int MCFQ_PTR_W = 3;
  localparam int MCFQ_ENTRY_W = 32;
  localparam int MCFQ_AF_THRESHOLD = 6;

  function automatic int wrap_ch(
    input int idx,
    input int n
  );
    return idx % n;
  endfunction

endpackage

// File: rtl/multi_channel_fifo_queue_round_robin_arbiter.sv
// Round-robin channel picker with a grant lock that pins
// the presented channel until the consumer pops it.
module round_robin_arbiter
  import multi_channel_fifo_queue_pkg::*;
#(
  parameter int NUM_CHANNELS = MCFQ_NUM_CHANNELS,
  parameter int CHANNEL_ID_WIDTH_IN_BITS = MCFQ_CH_ID_W
) (
  input  logic [NUM_CHANNELS-1:0]             req_in,
  input  logic [CHANNEL_ID_WIDTH_IN_BITS-1:0] rr_ptr_in,
  input  logic                                lock_in,
  input  logic [CHANNEL_ID_WIDTH_IN_BITS-1:0] lock_id_in,
  output logic [NUM_CHANNELS-1:0]             grant_out,
  output logic [CHANNEL_ID_WIDTH_IN_BITS-1:0] grant_id_out
);

  int c;

  always_comb begin
    grant_out = '0;
    grant_id_out = '0;
    c = 0;
    if (lock_in) begin
      grant_out = NUM_CHANNELS'(1) << lock_id_in;
      grant_id_out = lock_id_in;
    end else begin
      // Scan farthest-first so the nearest requester wins last.
      for (int i = NUM_CHANNELS; i >= 1; i--) begin
        c = wrap_ch(int'(rr_ptr_in) + i, NUM_CHANNELS);
        if (req_in[c]) begin
          grant_out = NUM_CHANNELS'(1) << c;
          grant_id_out = CHANNEL_ID_WIDTH_IN_BITS'(c);
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_fifo_queue.sv
// Per-channel FIFOs merged onto one consumer port by round robin.
// Define FIFO_QUEUE_ALMOST_FULL_EN to add almost_full_out.
module multi_channel_fifo_queue
  import multi_channel_fifo_queue_pkg::*;
#(
  parameter int NUM_CHANNELS = MCFQ_NUM_CHANNELS,
  parameter int CHANNEL_ID_WIDTH_IN_BITS = MCFQ_CH_ID_W,
  parameter int QUEUE_SIZE = MCFQ_QUEUE_SIZE,
  parameter int QUEUE_PTR_WIDTH_IN_BITS = MCFQ_PTR_W,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = MCFQ_ENTRY_W,
  parameter STORAGE_TYPE = "LUTRAM",
  parameter int ALMOST_FULL_THRESHOLD = MCFQ_AF_THRESHOLD
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic [NUM_CHANNELS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic [NUM_CHANNELS-1:0] request_valid_in,
  output logic [NUM_CHANNELS-1:0] issue_ack_out,
  output logic [NUM_CHANNELS-1:0] is_full_out,
  output logic [NUM_CHANNELS-1:0] is_empty_out,
`ifdef FIFO_QUEUE_ALMOST_FULL_EN
  output logic [NUM_CHANNELS-1:0] almost_full_out,
`endif
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  output logic [CHANNEL_ID_WIDTH_IN_BITS-1:0] request_channel_out,
  output logic request_valid_out,
  input  logic issue_ack_in
);

  localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int PW = QUEUE_PTR_WIDTH_IN_BITS;
  localparam int CNT_W = QUEUE_PTR_WIDTH_IN_BITS + 1;
  localparam int IDW = CHANNEL_ID_WIDTH_IN_BITS;

  if (ALMOST_FULL_THRESHOLD > QUEUE_SIZE ||
      (1 << PW) != QUEUE_SIZE ||
      $bits(STORAGE_TYPE) == 0) begin : g_bad_cfg
    $error("multi_channel_fifo_queue: bad parameters");
  end

  logic [PW-1:0] wr_ptr_q [NUM_CHANNELS];
  logic [PW-1:0] wr_ptr_d [NUM_CHANNELS];
  logic [PW-1:0] rd_ptr_q [NUM_CHANNELS];
  logic [PW-1:0] rd_ptr_d [NUM_CHANNELS];
  logic [CNT_W-1:0] count_q [NUM_CHANNELS];
  logic [CNT_W-1:0] count_d [NUM_CHANNELS];

  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic           lock_q;
  logic           lock_d;
  logic [IDW-1:0] lock_id_q;
  logic [IDW-1:0] lock_id_d;

  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;
  logic [NUM_CHANNELS-1:0] grant;
  logic [IDW-1:0]          grant_id;
  logic                    pop_any;
  logic [W-1:0]            head [NUM_CHANNELS];

  always_comb begin
    is_full_out = '0;
    is_empty_out = '0;
    push = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      is_full_out[c] = count_q[c] == CNT_W'(QUEUE_SIZE);
      is_empty_out[c] = count_q[c] == '0;
      push[c] = request_valid_in[c] & ~is_full_out[c];
    end
  end

  assign issue_ack_out = push;
  assign request_valid_out = |(~is_empty_out);
  assign pop_any = request_valid_out & issue_ack_in;
  assign pop = {NUM_CHANNELS{pop_any}} & grant;

`ifdef FIFO_QUEUE_ALMOST_FULL_EN
  always_comb begin
    almost_full_out = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      almost_full_out[c] =
        count_q[c] >= CNT_W'(ALMOST_FULL_THRESHOLD);
    end
  end
`endif

  round_robin_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .CHANNEL_ID_WIDTH_IN_BITS(IDW)
  ) u_arb (
    .req_in(~is_empty_out),
    .rr_ptr_in(rr_ptr_q),
    .lock_in(lock_q),
    .lock_id_in(lock_id_q),
    .grant_out(grant),
    .grant_id_out(grant_id)
  );

  // Storage is intentionally left unreset; pointers define validity.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    (* ram_style = STORAGE_TYPE *)
    logic [W-1:0] mem [QUEUE_SIZE];

    always_ff @(posedge clk_in) begin
      if (push[g]) begin
        mem[wr_ptr_q[g]] <= request_in[g*W +: W];
      end
    end

    assign head[g] = mem[rd_ptr_q[g]];
  end

  assign request_out = request_valid_out ? head[grant_id] : '0;
  assign request_channel_out = request_valid_out ? grant_id : '0;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      count_d[c] = count_q[c];
      if (push[c]) begin
        wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
      end
      if (push[c] && !pop[c]) begin
        count_d[c] = count_q[c] + CNT_W'(1);
      end else if (!push[c] && pop[c]) begin
        count_d[c] = count_q[c] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rr_ptr_d = pop_any ? grant_id : rr_ptr_q;
    lock_d = request_valid_out & ~issue_ack_in;
    lock_id_d = grant_id;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c] <= '0;
      end
      rr_ptr_q <= IDW'(NUM_CHANNELS - 1);
      lock_q <= 1'b0;
      lock_id_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c] <= count_d[c];
      end
      rr_ptr_q <= rr_ptr_d;
      lock_q <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_multi_channel_fifo_queue.sv
// Directed and random checks of multi_channel_fifo_queue
// against a queue-based reference model.
module tb_multi_channel_fifo_queue;

  localparam int N = 4;
  localparam int W = 32;
  localparam int QS = 8;
  localparam int AFT = 6;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset_n_in;
  logic [N*W-1:0] request_in;
  logic [N-1:0] request_valid_in;
  logic [N-1:0] issue_ack_out;
  logic [N-1:0] is_full_out;
  logic [N-1:0] is_empty_out;
`ifdef FIFO_QUEUE_ALMOST_FULL_EN
  logic [N-1:0] almost_full_out;
`endif
  logic [W-1:0] request_out;
  logic [1:0] request_channel_out;
  logic request_valid_out;
  logic issue_ack_in;

  multi_channel_fifo_queue dut (
    .clk_in(clk_in),
    .reset_n_in(reset_n_in),
    .request_in(request_in),
    .request_valid_in(request_valid_in),
    .issue_ack_out(issue_ack_out),
    .is_full_out(is_full_out),
    .is_empty_out(is_empty_out),
`ifdef FIFO_QUEUE_ALMOST_FULL_EN
    .almost_full_out(almost_full_out),
`endif
    .request_out(request_out),
    .request_channel_out(request_channel_out),
    .request_valid_out(request_valid_out),
    .issue_ack_in(issue_ack_in)
  );

  int total = 0;
  int bad = 0;

  logic [W-1:0] mq [N][$];
  logic [W-1:0] pend [N][$];
  int last_ch;
  bit locked;
  int lock_ch;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (locked) return lock_ch;
    for (int k = 1; k <= N; k++) begin
      if (mq[(last_ch + k) % N].size() > 0) return (last_ch + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      pend[c].delete();
    end
    last_ch = N - 1;
    locked = 0;
    lock_ch = 0;
  endtask

  task automatic cycle(input logic ack);
    int g;
    logic [N-1:0] e_ack, e_empty, e_full, e_af;
    logic [W-1:0] e_data;
    for (int c = 0; c < N; c++) begin
      if (pend[c].size() > 0) begin
        request_valid_in[c] = 1'b1;
        request_in[c*W +: W] = pend[c][0];
      end else begin
        request_valid_in[c] = 1'b0;
        request_in[c*W +: W] = $urandom;
      end
    end
    issue_ack_in = ack;
    #2;
    g = pick();
    e_data = '0;
    if (g >= 0) e_data = mq[g][0];
    for (int c = 0; c < N; c++) begin
      e_ack[c] = request_valid_in[c] && (mq[c].size() < QS);
      e_empty[c] = mq[c].size() == 0;
      e_full[c] = mq[c].size() == QS;
      e_af[c] = mq[c].size() >= AFT;
    end
    chk("valid", 64'(request_valid_out), 64'(g >= 0));
    chk("chan", 64'(request_channel_out), 64'(g >= 0 ? g : 0));
    chk("data", 64'(request_out), 64'(e_data));
    chk("push_ack", 64'(issue_ack_out), 64'(e_ack));
    chk("empty", 64'(is_empty_out), 64'(e_empty));
    chk("full", 64'(is_full_out), 64'(e_full));
`ifdef FIFO_QUEUE_ALMOST_FULL_EN
    chk("afull", 64'(almost_full_out), 64'(e_af));
`endif
    @(posedge clk_in);
    for (int c = 0; c < N; c++) begin
      if (e_ack[c]) mq[c].push_back(pend[c].pop_front());
    end
    if (g >= 0) begin
      if (ack) begin
        void'(mq[g].pop_front());
        last_ch = g;
        locked = 0;
      end else begin
        locked = 1;
        lock_ch = g;
      end
    end
    @(negedge clk_in);
  endtask

  // Drops reset mid-cycle and checks outputs before any clock edge.
  task automatic reset_and_check();
    reset_n_in = 1'b0;
    #1;
    chk("rst_valid", 64'(request_valid_out), 64'(0));
    chk("rst_chan", 64'(request_channel_out), 64'(0));
    chk("rst_data", 64'(request_out), 64'(0));
    chk("rst_empty", 64'(is_empty_out), 64'(4'hF));
    chk("rst_full", 64'(is_full_out), 64'(0));
    chk("rst_ack", 64'(issue_ack_out), 64'(request_valid_in));
`ifdef FIFO_QUEUE_ALMOST_FULL_EN
    chk("rst_afull", 64'(almost_full_out), 64'(0));
`endif
    model_clear();
    @(negedge clk_in);
    reset_n_in = 1'b1;
  endtask

  initial begin
    reset_n_in = 1'b0;
    request_in = '0;
    request_valid_in = 4'b1010;
    issue_ack_in = 1'b0;
    model_clear();
    #1;
    reset_and_check();

    // ch0 stream with consumer always ready
    pend[0].push_back(32'hFFFF_FFFE);
    pend[0].push_back(32'hFFFF_FFFD);
    pend[0].push_back(32'hFFFF_FFFC);
    pend[0].push_back(32'hFFFF_FFFB);
    for (int i = 0; i < 7; i++) cycle(1'b1);
    chk("t1_empty0", 64'(is_empty_out[0]), 64'(1));

    // fill ch1, ninth push refused
    reset_and_check();
    for (int i = 1; i <= 9; i++) pend[1].push_back(32'hDEAD_0000 + i);
    for (int i = 0; i < 10; i++) cycle(1'b0);
    chk("t2_full1", 64'(is_full_out[1]), 64'(1));
    pend[1].delete();
    for (int i = 0; i < 9; i++) cycle(1'b1);
    chk("t2_empty1", 64'(is_empty_out[1]), 64'(1));

    // round-robin across all channels without bubbles
    reset_and_check();
    for (int c = 0; c < N; c++) begin
      pend[c].push_back(32'h1000_0000 * (c + 1) + 1);
      pend[c].push_back(32'h1000_0000 * (c + 1) + 2);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_seq", 64'(request_channel_out), 64'(i % 4));
      cycle(1'b1);
    end
    chk("t3_empty", 64'(is_empty_out), 64'(4'hF));

    // grant lock on ch2 while ch0 fills
    reset_and_check();
    pend[2].push_back(32'h2222_0001);
    pend[2].push_back(32'h2222_0002);
    pend[3].push_back(32'h3333_0001);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 5; i++) begin
      pend[0].push_back(32'hA0 + i);
      chk("t4_lock_ch", 64'(request_channel_out), 64'(2));
      chk("t4_lock_data", 64'(request_out), 64'(32'h2222_0001));
      cycle(1'b0);
    end
    cycle(1'b1);
    chk("t4_next", 64'(request_channel_out), 64'(3));
    for (int i = 0; i < 10; i++) cycle(1'b1);

    // simultaneous push/pop at count 4
    reset_and_check();
    for (int i = 0; i < 4; i++) pend[0].push_back(32'h5000 + i);
    for (int i = 0; i < 4; i++) cycle(1'b0);
    pend[0].push_back(32'h5004);
    cycle(1'b1);
    pend[0].push_back(32'h5005);
    pend[0].push_back(32'h5006);
    cycle(1'b0);
    cycle(1'b0);
`ifdef FIFO_QUEUE_ALMOST_FULL_EN
    chk("t5_afull6", 64'(almost_full_out[0]), 64'(1));
`endif
    for (int i = 0; i < 8; i++) cycle(1'b1);

    // reset while every channel holds entries
    reset_and_check();
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < 4; i++) pend[c].push_back($urandom);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0);
    #3;
    reset_and_check();
    for (int i = 0; i < 4; i++) cycle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (pend[c].size() < 3 && $urandom_range(2) == 0)
          pend[c].push_back($urandom);
      end
      cycle(1'($urandom_range(3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
